tblink_rpc_tip_tx: RTL and testbench

TIP-side packet framer that sits directly upstream of the RPC endpoint's TIP-input port. It accepts a byte message from the TIP, buffers it whole in a store-and-forward buffer, and then emits a network packet: a header byte carrying the destination address, a count byte, and the payload. The endpoint forwards that packet onto the network unchanged, so framing here must match the endpoint's packet format exactly.

---
 rtl/tblink_rpc_pkg.sv | 26 ++
 rtl/tblink_rpc_pkt_buf.sv | 26 ++
 rtl/tblink_rpc_tip_tx.sv | 161 ++++++++++++++++
 tb/tb_tblink_rpc_tip_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tblink_rpc_pkg.sv
// Shared types and constants for the TBLink RPC TIP-side framer.
package tblink_rpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_WAIT,
        ST_HDR,
        ST_CNT,
        ST_DATA
    } tx_state_e;

    localparam logic [6:0] ADDR_RESERVED   = 7'd0;
    localparam int         MAX_PKT_PAYLOAD = 256;

    function automatic logic [7:0] mk_hdr(input logic [6:0] dst);
        return {1'b0, dst};
    endfunction

    // (len-1)[7:0] equals len[7:0]-1 modulo 256, so len=256 yields 8'hFF
    function automatic logic [7:0] mk_cnt(input logic [8:0] len);
        return len[7:0] - 8'd1;
    endfunction

endpackage

// File: rtl/tblink_rpc_pkt_buf.sv
// Store-and-forward payload RAM: one write port, one registered read port, array not reset.
module tblink_rpc_pkt_buf
    import tblink_rpc_pkg::*;
#(
    parameter int DEPTH = MAX_PKT_PAYLOAD,
    parameter int AW    = 8
) (
    input  logic          uclock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdat,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdat
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdat_q;

    always_ff @(posedge uclock) begin
        if (we) mem[waddr] <= wdat;
        rdat_q <= mem[raddr];
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/tblink_rpc_tip_tx.sv
// TIP message to network packet framer (header, count, payload), store-and-forward.
// Optional packet counter output enabled by defining TBLINK_RPC_TIP_TX_STATS_EN.
module tblink_rpc_tip_tx
    import tblink_rpc_pkg::*;
#(
    parameter int MAX_PAYLOAD = MAX_PKT_PAYLOAD
) (
    input  logic        uclock,
    input  logic        reset_n,
    input  logic        hreq_i,
    input  logic [7:0]  msg_dat,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic        msg_last,
    input  logic [6:0]  msg_dst,
    output logic [7:0]  pkt_dat,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        err_o
`ifdef TBLINK_RPC_TIP_TX_STATS_EN
   ,output logic [15:0] pkt_count
`endif
);

    localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [8:0] LEN_MAX = 9'(MAX_PAYLOAD);

    tx_state_e  state_q, state_d;
    logic [8:0] len_q, len_d;
    logic [8:0] nxt_q, nxt_d;
    logic [6:0] dst_q, dst_d;
    logic       msg_ready_q, msg_ready_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic [7:0] pkt_dat_q, pkt_dat_d;
    logic       err_q, err_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    rd_dat;
    logic          msg_beat, pkt_beat;

    assign msg_beat = msg_valid && msg_ready_q;
    assign pkt_beat = pkt_valid_q && pkt_ready;

    tblink_rpc_pkt_buf #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
        .uclock (uclock),
        .we     (wr_en),
        .waddr  (wr_addr),
        .wdat   (msg_dat),
        .raddr  (nxt_d[AW-1:0]),
        .rdat   (rd_dat)
    );

    // nxt_q indexes the next payload byte to load; addressing the RAM with nxt_d
    // keeps rd_dat == buffer[nxt_q] every cycle, stalls included.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nxt_d       = nxt_q;
        dst_d       = dst_q;
        pkt_valid_d = pkt_valid_q;
        pkt_dat_d   = pkt_dat_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        wr_addr     = len_q[AW-1:0];
        case (state_q)
            ST_IDLE: if (msg_beat) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                dst_d   = msg_dst;
                len_d   = 9'd1;
                state_d = msg_last ? ST_WAIT : ST_FILL;
            end
            ST_FILL: if (msg_beat) begin
                wr_en = 1'b1;
                len_d = len_q + 9'd1;
                if (msg_last) begin
                    state_d = ST_WAIT;
                end else if (len_d == LEN_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (msg_beat && msg_last) state_d = ST_WAIT;
            ST_WAIT: begin
                if (dst_q == ADDR_RESERVED) begin
                    err_d   = 1'b1;
                    len_d   = '0;
                    state_d = ST_IDLE;
                end else if (!hreq_i) begin
                    pkt_valid_d = 1'b1;
                    pkt_dat_d   = mk_hdr(dst_q);
                    nxt_d       = '0;
                    state_d     = ST_HDR;
                end
            end
            ST_HDR: if (pkt_beat) begin
                pkt_dat_d = mk_cnt(len_q);
                state_d   = ST_CNT;
            end
            ST_CNT: if (pkt_beat) begin
                pkt_dat_d = rd_dat;
                nxt_d     = 9'd1;
                state_d   = ST_DATA;
            end
            ST_DATA: if (pkt_beat) begin
                if (nxt_q == len_q) begin
                    pkt_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    pkt_dat_d = rd_dat;
                    nxt_d     = nxt_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        msg_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge uclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            nxt_q       <= '0;
            dst_q       <= '0;
            msg_ready_q <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_dat_q   <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nxt_q       <= nxt_d;
            dst_q       <= dst_d;
            msg_ready_q <= msg_ready_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_dat_q   <= pkt_dat_d;
            err_q       <= err_d;
        end
    end

    assign msg_ready = msg_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_dat   = pkt_dat_q;
    assign err_o     = err_q;

`ifdef TBLINK_RPC_TIP_TX_STATS_EN
    logic        pkt_done;
    logic [15:0] pkt_count_q;

    assign pkt_done = (state_q == ST_DATA) && pkt_beat && (nxt_q == len_q);

    always_ff @(posedge uclock or negedge reset_n) begin
        if (!reset_n)      pkt_count_q <= '0;
        else if (pkt_done) pkt_count_q <= pkt_count_q + 16'd1;
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_tblink_rpc_tip_tx.sv
// Randomized directed bench for tblink_rpc_tip_tx against a message-to-packet reference model.
module tb_tblink_rpc_tip_tx;

    typedef logic [7:0] u8_t;
    localparam int MAXP = 256;

    logic       uclock = 1'b0;
    logic       reset_n;
    logic       hreq_i;
    logic [7:0] msg_dat;
    logic       msg_valid;
    logic       msg_ready;
    logic       msg_last;
    logic [6:0] msg_dst;
    logic [7:0] pkt_dat;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       err_o;
`ifdef TBLINK_RPC_TIP_TX_STATS_EN
    logic [15:0] pkt_count;
`endif

    int nvec = 0;
    int nerr = 0;
    bit err_exp = 1'b0;
    int pkt_exp = 0;

    tblink_rpc_tip_tx #(.MAX_PAYLOAD(MAXP)) dut (
        .uclock    (uclock),
        .reset_n   (reset_n),
        .hreq_i    (hreq_i),
        .msg_dat   (msg_dat),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_last  (msg_last),
        .msg_dst   (msg_dst),
        .pkt_dat   (pkt_dat),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .err_o     (err_o)
`ifdef TBLINK_RPC_TIP_TX_STATS_EN
       ,.pkt_count (pkt_count)
`endif
    );

    always #5 uclock = ~uclock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: reserved dst drops the packet; otherwise header, count, first min(N,MAX) bytes.
    function automatic void model(input u8_t msg[$], input logic [6:0] dst,
                                  output u8_t pkt[$], output bit err);
        int n;
        pkt = {};
        n = (msg.size() > MAXP) ? MAXP : msg.size();
        err = (dst == 7'd0) || (msg.size() > MAXP);
        if (dst != 7'd0) begin
            pkt.push_back({1'b0, dst});
            pkt.push_back(u8_t'(n - 1));
            for (int i = 0; i < n; i++) pkt.push_back(msg[i]);
        end
    endfunction

    task automatic send_msg(input u8_t msg[$], input logic [6:0] dst, input bit gaps);
        int cyc;
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                msg_valid = 1'b0;
                @(posedge uclock); #1;
            end
            msg_dat   = msg[i];
            msg_valid = 1'b1;
            msg_last  = (i == msg.size() - 1);
            msg_dst   = (i == 0) ? dst : 7'($urandom_range(0, 127));
            cyc = 0;
            while (!msg_ready && cyc < 200) begin
                @(posedge uclock); #1;
                cyc++;
            end
            if (cyc >= 200) begin
                chk("msg_ready_timeout", 32'(cyc), 32'd0);
                break;
            end
            @(posedge uclock); #1;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic recv_pkt(input u8_t exp_q[$], input bit rnd, output int first, output int span);
        int  idx = 0;
        int  cyc = 0;
        bit  stall = 1'b0;
        u8_t prev = '0;
        first = -1;
        span  = 0;
        while (idx < exp_q.size() && cyc < 5000) begin
            if (pkt_valid) begin
                if (first < 0) first = cyc;
                if (stall) chk("stall_stable", pkt_dat, prev);
                chk("msg_ready_busy", msg_ready, 1'b0);
            end
            pkt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hreq_i    = (rnd && pkt_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (pkt_valid && pkt_ready) begin
                chk("pkt_dat", pkt_dat, exp_q[idx]);
                idx++;
                span = cyc - first + 1;
            end
            stall = pkt_valid && !pkt_ready;
            prev  = pkt_dat;
            @(posedge uclock); #1;
            cyc++;
        end
        if (idx < exp_q.size()) chk("pkt_timeout", 32'(idx), 32'(exp_q.size()));
        pkt_ready = 1'b0;
        hreq_i    = 1'b0;
        chk("pkt_valid_after", pkt_valid, 1'b0);
        chk("msg_ready_after", msg_ready, 1'b1);
    endtask

    task automatic do_pkt(input u8_t msg[$], input logic [6:0] dst, input bit rnd,
                          input bit hold, output int first, output int span);
        u8_t exp_q[$];
        bit  e;
        model(msg, dst, exp_q, e);
        err_exp |= e;
        first = -1;
        span  = 0;
        hreq_i = hold;
        send_msg(msg, dst, rnd);
        chk("msg_ready_wait", msg_ready, 1'b0);
        chk("pkt_valid_wait", pkt_valid, 1'b0);
        if (exp_q.size() == 0) begin
            repeat (4) begin
                @(posedge uclock); #1;
                chk("no_pkt", pkt_valid, 1'b0);
            end
            chk("msg_ready_drop", msg_ready, 1'b1);
        end else begin
            if (hold) begin
                repeat (5) begin
                    @(posedge uclock); #1;
                    chk("hreq_hold", pkt_valid, 1'b0);
                end
                hreq_i = 1'b0;
                @(posedge uclock); #1;
                chk("hreq_release_valid", pkt_valid, 1'b1);
                chk("hreq_release_hdr", pkt_dat, exp_q[0]);
            end
            recv_pkt(exp_q, rnd, first, span);
            pkt_exp++;
        end
        chk("err_o", err_o, err_exp);
    endtask

    function automatic void mk_rand(input int n, output u8_t msg[$]);
        msg = {};
        for (int i = 0; i < n; i++) msg.push_back(u8_t'($urandom_range(0, 255)));
    endfunction

    initial begin
        u8_t msg[$];
        int  first, span;
        reset_n = 1'b0; hreq_i = 1'b0; msg_dat = '0; msg_valid = 1'b0;
        msg_last = 1'b0; msg_dst = '0; pkt_ready = 1'b0;
        repeat (3) @(posedge uclock); #1;
        chk("rst_msg_ready", msg_ready, 1'b0);
        chk("rst_pkt_valid", pkt_valid, 1'b0);
        chk("rst_pkt_dat", pkt_dat, 8'h00);
        chk("rst_err", err_o, 1'b0);
        reset_n = 1'b1; #1;
        chk("ready_pre_edge", msg_ready, 1'b0);
        @(posedge uclock); #1;
        chk("ready_post_edge", msg_ready, 1'b1);

        msg = '{8'h11, 8'h22, 8'h33};
        do_pkt(msg, 7'd5, 1'b0, 1'b0, first, span);
        chk("t1_first", 32'(first), 32'd1);
        chk("t1_span", 32'(span), 32'd5);

        msg = '{8'hA5};
        do_pkt(msg, 7'd1, 1'b0, 1'b0, first, span);
        chk("t2_span", 32'(span), 32'd3);

        mk_rand(256, msg);
        do_pkt(msg, 7'd77, 1'b0, 1'b0, first, span);
        chk("full_span", 32'(span), 32'd258);

        mk_rand(300, msg);
        do_pkt(msg, 7'd9, 1'b1, 1'b0, first, span);

        mk_rand(4, msg);
        do_pkt(msg, 7'd0, 1'b1, 1'b0, first, span);
        mk_rand(3, msg);
        do_pkt(msg, 7'd2, 1'b0, 1'b0, first, span);

        mk_rand(6, msg);
        do_pkt(msg, 7'd100, 1'b1, 1'b1, first, span);

        for (int k = 0; k < 10; k++) begin
            int n;
            logic [6:0] d;
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 270) : $urandom_range(1, 16);
            d = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            mk_rand(n, msg);
            do_pkt(msg, d, 1'b1, 1'($urandom_range(0, 1)), first, span);
        end

`ifdef TBLINK_RPC_TIP_TX_STATS_EN
        chk("pkt_count", pkt_count, 32'(pkt_exp));
`endif

        // Abort a packet mid-payload with reset
        mk_rand(10, msg);
        send_msg(msg, 7'd12, 1'b0);
        pkt_ready = 1'b1;
        repeat (6) begin
            @(posedge uclock); #1;
        end
        chk("pre_abort_valid", pkt_valid, 1'b1);
        reset_n = 1'b0; #1;
        chk("abort_valid", pkt_valid, 1'b0);
        chk("abort_dat", pkt_dat, 8'h00);
        chk("abort_ready", msg_ready, 1'b0);
        chk("abort_err", err_o, 1'b0);
        err_exp = 1'b0;
        pkt_exp = 0;
        pkt_ready = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge uclock); #1;
        chk("post_abort_ready", msg_ready, 1'b1);
        chk("post_abort_valid", pkt_valid, 1'b0);
        msg = '{8'hC3, 8'h3C};
        do_pkt(msg, 7'd3, 1'b0, 1'b0, first, span);
        chk("post_abort_span", 32'(span), 32'd4);
`ifdef TBLINK_RPC_TIP_TX_STATS_EN
        chk("pkt_count_post_rst", pkt_count, 32'(pkt_exp));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
